fetch_pc_seq: RTL
=================

// Module: fetch_pc_seq
//
// PURPOSE
// Fetch-side PC sequencer for the RV32 core. Generates the instruction fetch
// address stream and holds it stable across the fetch handshake. Absorbs
// redirects from the execute-stage PC-select logic (o_pc_select/o_pc_target).
// Owns a small direct-mapped BTB with 2-bit counters and produces the
// per-fetch branch_pred flag that travels down the pipe to PC select.
//
// PARAMETERS
// IADDR_SPACE_BITS   32   instruction address width
// RESET_ADDR         '0   first fetch address after reset
// BTB_ENTRIES        8    BTB depth; power of 2, >= 2
// BRANCH_PREDICTION  1    0: BTB never predicts; o_branch_pred tied 0
//
// PORTS
// i_clk            in   1      clock; all state updates on rising edge
// i_reset          in   1      reset; asynchronous, active-high
// o_req            out  1      fetch request valid
// o_addr           out  IAB    fetch address (IAB = IADDR_SPACE_BITS)
// o_branch_pred    out  1      BTB predicted-taken for o_addr; valid with o_req
// i_ack            in   1      fetch bus accepted o_addr this cycle
// i_stall          in   1      backend cannot take more instructions
// i_pc_select      in   1      execute redirect strobe
// i_pc_target      in   IAB    redirect address
// o_flush          out  1      drop all in-flight fetches (registered)
// i_upd_valid      in   1      BTB training strobe for a resolved branch/jump
// i_upd_pc         in   IAB    PC of the resolved instruction
// i_upd_target     in   IAB    resolved target
// i_upd_taken      in   1      resolved direction
//
// BEHAVIOUR
// Reset values: state RESET, pc=RESET_ADDR, o_req=0, o_flush=0,
//   o_branch_pred=0, all BTB valid bits=0. Reset mid-operation aborts
//   everything immediately.
// States:
//   RESET: o_req=0. Goes to RUN next cycle (or REDIRECT on redirect).
//   RUN:   o_req=1. With !i_ack: pc held and o_branch_pred held.
//          i_ack & !i_stall: pc <= next, stay RUN.
//          i_ack & i_stall: pc <= next, go to HOLD.
//          i_stall without i_ack does not drop o_req.
//   HOLD:  o_req=0, pc held. Goes to RUN when !i_stall.
//   REDIRECT: o_req=0, o_flush=1. Goes to RUN next cycle.
// Next pc = BTB target if predicted taken, else pc+4. Addition wraps modulo
//   2^IAB.
// Redirect: i_pc_select=1 in any state:
//   - pc <= {i_pc_target[IAB-1:1],1'b0}; state <= REDIRECT.
//   - Has priority over i_ack, i_stall and BTB prediction.
//   - An unacked request is abandoned. A request acked in the same cycle is
//     discarded downstream via o_flush.
//   - Redirect while in REDIRECT: reload pc and stay in REDIRECT one more
//     cycle.
// BTB addressing: idx = pc[log2(BTB_ENTRIES)+1:2]; tag = remaining upper
//   bits. Each entry holds valid, tag, target and a 2-bit counter.
// Prediction:
//   - predict = BRANCH_PREDICTION & valid & tag match & ctr[1].
//   - Lookup is combinational on pc.
// BTB update on i_upd_valid:
//   - Hit: ctr saturating +1 if taken, -1 if not.
//   - Hit and taken: target <= i_upd_target.
//   - Miss and taken: allocate valid=1, tag, target, ctr=2'b10.
//   - Miss and not taken: no change.
//   - The write is visible to lookups from the next cycle; a same-cycle
//     lookup of the same index sees the old entry.
//
// TESTING
// 1. Reset (RESET_ADDR=0x100), i_ack=1 constant -> o_req low 1 cycle, then
//    o_addr 0x100, 0x104, 0x108 on consecutive cycles.
// 2. i_ack=0 for 3 cycles at 0x104 -> o_addr/o_branch_pred stable at 0x104;
//    o_req stays 1 with i_stall=1.
// 3. i_pc_select=1, target 0x2001, same cycle as i_ack -> o_flush=1 and
//    o_req=0 next cycle; then o_addr=0x2000.
// 4. Train pc 0x110 taken->0x400 twice, then fetch 0x110 ->
//    o_branch_pred=1, next o_addr 0x400. Two not-taken updates ->
//    prediction off.
// 5. i_stall=1 at ack -> HOLD with o_req=0; release -> resume at pc+4.
//    Redirect during HOLD -> REDIRECT, then RUN at the new target.
// 6. Async i_reset pulse mid-HOLD with BTB populated -> o_req=0 at once;
//    fetch restarts at RESET_ADDR; no predictions until retrained.

Source files
------------

// File: rtl/fetch_pc_seq.sv
// Fetch-side PC sequencer: drives the fetch address stream, absorbs execute redirects
// and owns a direct-mapped BTB with 2-bit counters for next-PC prediction.
module fetch_pc_seq #(
    parameter int                          IADDR_SPACE_BITS  = 32,
    parameter logic [IADDR_SPACE_BITS-1:0] RESET_ADDR        = '0,
    parameter int                          BTB_ENTRIES       = 8,
    parameter bit                          BRANCH_PREDICTION = 1'b1
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    output logic                        o_req,
    output logic [IADDR_SPACE_BITS-1:0] o_addr,
    output logic                        o_branch_pred,
    input  logic                        i_ack,
    input  logic                        i_stall,
    input  logic                        i_pc_select,
    input  logic [IADDR_SPACE_BITS-1:0] i_pc_target,
    output logic                        o_flush,
    input  logic                        i_upd_valid,
    input  logic [IADDR_SPACE_BITS-1:0] i_upd_pc,
    input  logic [IADDR_SPACE_BITS-1:0] i_upd_target,
    input  logic                        i_upd_taken
);
    localparam int IAB   = IADDR_SPACE_BITS;
    localparam int IDX_W = $clog2(BTB_ENTRIES);
    localparam int TAG_W = IAB - IDX_W - 2;

    typedef enum logic [1:0] {S_RESET, S_RUN, S_HOLD, S_REDIRECT} state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [IAB-1:0]          r_pc;

    logic [BTB_ENTRIES-1:0]  r_btb_vld;
    logic [TAG_W-1:0]        r_btb_tag [BTB_ENTRIES];
    logic [IAB-1:0]          r_btb_tgt [BTB_ENTRIES];
    logic [1:0]              r_btb_ctr [BTB_ENTRIES];

    logic                    r_hold_vld;
    logic                    r_hold_pred;
    logic [IAB-1:0]          r_hold_tgt;

    logic [IDX_W-1:0]        w_idx;
    logic [TAG_W-1:0]        w_tag;
    logic                    w_lookup_pred;
    logic                    w_pred;
    logic [IAB-1:0]          w_tgt;
    logic [IAB-1:0]          w_pc_next;
    logic                    w_hold_capture;

    logic [IDX_W-1:0]        w_upd_idx;
    logic [TAG_W-1:0]        w_upd_tag;
    logic                    w_upd_hit;
    logic                    w_unused_bits;

    function automatic logic [1:0] ctr_inc(input logic [1:0] c);
        return (c == 2'b11) ? c : c + 2'b01;
    endfunction

    function automatic logic [1:0] ctr_dec(input logic [1:0] c);
        return (c == 2'b00) ? c : c - 2'b01;
    endfunction

    assign w_unused_bits = ^{i_upd_pc[1:0], i_pc_target[0]};

    // BTB lookup on the current fetch PC
    assign w_idx         = r_pc[IDX_W+1:2];
    assign w_tag         = r_pc[IAB-1:IDX_W+2];
    assign w_lookup_pred = BRANCH_PREDICTION && r_btb_vld[w_idx]
                           && (r_btb_tag[w_idx] == w_tag) && r_btb_ctr[w_idx][1];

    // A request waiting for i_ack keeps the prediction it was first presented with,
    // so BTB training during the wait cannot change o_branch_pred or the next PC.
    assign w_pred    = r_hold_vld ? r_hold_pred : w_lookup_pred;
    assign w_tgt     = r_hold_vld ? r_hold_tgt  : r_btb_tgt[w_idx];
    assign w_pc_next = w_pred ? w_tgt : r_pc + IAB'(4);

    assign w_hold_capture = (r_state == S_RUN) && !i_ack && !i_pc_select;

    assign w_upd_idx = i_upd_pc[IDX_W+1:2];
    assign w_upd_tag = i_upd_pc[IAB-1:IDX_W+2];
    assign w_upd_hit = r_btb_vld[w_upd_idx] && (r_btb_tag[w_upd_idx] == w_upd_tag);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_RESET;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (i_pc_select) begin
            w_next_state = S_REDIRECT;
        end else begin
            case (r_state)
                S_RESET:    w_next_state = S_RUN;
                S_REDIRECT: w_next_state = S_RUN;
                S_RUN: begin
                    if (i_ack) begin
                        w_next_state = i_stall ? S_HOLD : S_RUN;
                    end
                end
                S_HOLD: begin
                    if (!i_stall) begin
                        w_next_state = S_RUN;
                    end
                end
                default:    w_next_state = S_RESET;
            endcase
        end
    end

    always_comb begin
        o_req         = (r_state == S_RUN);
        o_flush       = (r_state == S_REDIRECT);
        o_branch_pred = (r_state == S_RUN) && w_pred;
        o_addr        = r_pc;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_pc <= RESET_ADDR;
        end else if (i_pc_select) begin
            r_pc <= {i_pc_target[IAB-1:1], 1'b0};
        end else if ((r_state == S_RUN) && i_ack) begin
            r_pc <= w_pc_next;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_hold_vld  <= 1'b0;
            r_hold_pred <= 1'b0;
        end else if (w_hold_capture) begin
            r_hold_vld  <= 1'b1;
            r_hold_pred <= w_pred;
        end else begin
            r_hold_vld  <= 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_hold_capture) begin
            r_hold_tgt <= w_tgt;
        end
    end

    // BTB training; writes become visible to lookups on the following cycle
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_btb_vld <= '0;
        end else if (i_upd_valid && !w_upd_hit && i_upd_taken) begin
            r_btb_vld[w_upd_idx] <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_upd_valid) begin
            if (w_upd_hit) begin
                r_btb_ctr[w_upd_idx] <= i_upd_taken ? ctr_inc(r_btb_ctr[w_upd_idx])
                                                    : ctr_dec(r_btb_ctr[w_upd_idx]);
                if (i_upd_taken) begin
                    r_btb_tgt[w_upd_idx] <= i_upd_target;
                end
            end else if (i_upd_taken) begin
                r_btb_tag[w_upd_idx] <= w_upd_tag;
                r_btb_tgt[w_upd_idx] <= i_upd_target;
                r_btb_ctr[w_upd_idx] <= 2'b10;
            end
        end
    end
endmodule
